// File: rtl/ham_enc_sched.sv
// ham_enc_sched: round-robin scheduler sharing one Hamming(15,11) encoder, feeding a 2-entry output FIFO.
// Define HAM_ENC_SCHED_ERR_INJ_EN to add inj_en/inj_pos single-bit error injection on push.
module ham_15_11_encoder (
  input  logic [10:0] data,
  output logic [14:0] code
);
  logic p1, p2, p4, p8;
  assign p1 = ^{data[10], data[8], data[6], data[4], data[3], data[1], data[0]};
  assign p2 = ^{data[10], data[9], data[6], data[5], data[3], data[2], data[0]};
  assign p4 = ^{data[10], data[9], data[8], data[7], data[3], data[2], data[1]};
  assign p8 = ^data[10:4];
  assign code = {data[10:4], p8, data[3:1], p4, data[0], p2, p1};
endmodule

module ham_enc_sched #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [11*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   out_valid,
  output logic [14:0]            out_code,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_ready,
`ifdef HAM_ENC_SCHED_ERR_INJ_EN
  input  logic                   inj_en,
  input  logic [3:0]             inj_pos,
`endif
  output logic                   busy
);
  localparam logic [1:0] EMPTY = 2'd0, TWO = 2'd2;
  logic [1:0] count;
  logic [SRC_W-1:0] rr_ptr, gnt_idx, rr_next;
  logic [SRC_W:0] sum;
  logic [2*NUM_REQ-1:0] rot;
  logic gnt_any, push, pop, wr_ptr, rd_ptr;
  logic [10:0] enc_data;
  logic [14:0] enc_code, store_code;
  logic [14:0] mem_code [2];
  logic [SRC_W-1:0] mem_src [2];
  // Rotate so bit 0 is rr_ptr; the lowest set bit after rotation is the winner.
  always_comb begin
    rot = {req_valid, req_valid} >> rr_ptr;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) begin
        gnt_any = 1'b1;
        sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
        gnt_idx = (sum >= (SRC_W+1)'(NUM_REQ)) ? SRC_W'(sum - (SRC_W+1)'(NUM_REQ)) : SRC_W'(sum);
      end
  end
  assign push = gnt_any && count != TWO;
  assign pop = out_valid && out_ready;
  assign req_ready = push ? NUM_REQ'(1) << gnt_idx : '0;
  assign rr_next = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign enc_data = 11'(req_data >> (11 * gnt_idx));
  ham_15_11_encoder u_enc (.data(enc_data), .code(enc_code));
`ifdef HAM_ENC_SCHED_ERR_INJ_EN
  assign store_code = enc_code ^ ((inj_en && inj_pos != 4'd15) ? 15'(1) << inj_pos : 15'd0);
`else
  assign store_code = enc_code;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= EMPTY;
      rr_ptr <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
        rr_ptr <= rr_next;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_code[wr_ptr] <= store_code;
      mem_src[wr_ptr] <= gnt_idx;
    end
  end
  assign out_valid = count != EMPTY;
  assign busy = out_valid;
  assign out_code = mem_code[rd_ptr];
  assign out_src = mem_src[rd_ptr];
endmodule

// File: tb/tb_ham_enc_sched.sv
// tb_ham_enc_sched: randomized and directed bench with a queue scoreboard and a behavioural Hamming/arbiter model.
module tb_ham_enc_sched;
  localparam int N = 4;
  localparam int SW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [11*N-1:0] req_data = '0;
  logic out_valid, busy, out_ready = 1'b0;
  logic [14:0] out_code;
  logic [SW-1:0] out_src;
  logic inj_en = 1'b0;
  logic [3:0] inj_pos = 4'd0;
  int tests = 0, fails = 0;
  logic [SW+14:0] exp_q[$];
  logic mon_pop = 1'b0, hold = 1'b0;
  logic [14:0] prev_code;
  logic [SW-1:0] prev_src;
  int m_rr = 0;

  ham_enc_sched #(.NUM_REQ(N), .SRC_W(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_code(out_code), .out_src(out_src), .out_ready(out_ready),
`ifdef HAM_ENC_SCHED_ERR_INJ_EN
    .inj_en(inj_en), .inj_pos(inj_pos),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Positions 1..15; powers of two hold parity, the rest hold data LSB first.
  function automatic logic [14:0] ham_ref(input logic [10:0] d);
    logic [15:1] p;
    logic x;
    int j;
    p = '0;
    j = 0;
    for (int pos = 1; pos <= 15; pos++)
      if ((pos & (pos - 1)) != 0) begin
        p[pos] = d[j];
        j++;
      end
    for (int b = 0; b < 4; b++) begin
      x = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if ((pos & (1 << b)) != 0) x ^= p[pos];
      p[1 << b] = x;
    end
    return p[15:1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [SW+14:0] e;
    mon_pop = 1'b0;
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (hold && out_valid) begin
        chk("hold_code", 32'(out_code), 32'(prev_code));
        chk("hold_src", 32'(out_src), 32'(prev_src));
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_code", 32'(out_code), 32'(e[14:0]));
        chk("sb_src", 32'(out_src), 32'(e[SW+14:15]));
        mon_pop = 1'b1;
      end
      hold = out_valid && !out_ready;
      prev_code = out_code;
      prev_src = out_src;
    end else hold = 1'b0;
  end

  always @(negedge clk) begin
    logic [14:0] c;
    logic [N-1:0] er;
    int g;
    #1;
    if (rst) begin
      exp_q.delete();
      m_rr = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      er = '0;
      if (g >= 0 && exp_q.size() + int'(mon_pop) < 2) begin
        er[g] = 1'b1;
        c = ham_ref(req_data[11*g +: 11]);
`ifdef HAM_ENC_SCHED_ERR_INJ_EN
        if (inj_en && inj_pos != 4'd15) c ^= 15'(1) << inj_pos;
`endif
        exp_q.push_back({SW'(g), c});
        m_rr = (g + 1) % N;
      end
      chk("req_ready", 32'(req_ready), 32'(er));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [10:0] d);
    req_valid = '0;
    req_valid[i] = 1'b1;
    req_data[11*i +: 11] = d;
    step();
    req_valid = '0;
  endtask

  initial begin
    logic [10:0] words [3];
    int w;
    words = '{11'h0AA, 11'h0BB, 11'h0CC};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    send(0, 11'h001);
    chk("enc_001", 32'(out_code), 32'h0007);
    chk("enc_001_src", 32'(out_src), 32'd0);
    send(1, 11'h000);
    chk("enc_000", 32'(out_code), 32'h0000);
    chk("enc_000_src", 32'(out_src), 32'd1);
    send(2, 11'h7FF);
    chk("enc_7ff", 32'(out_code), 32'h7FFF);
    send(3, 11'h400);
    chk("enc_400", 32'(out_code), 32'h408B);
    chk("enc_400_src", 32'(out_src), 32'd3);
    step();
    out_ready = 1'b0;
    w = 0;
    for (int c = 0; c < 14 && w < 3; c++) begin
      if (c == 4) begin
        chk("bp_accepts", 32'(w), 32'd2);
        chk("bp_full_ready", 32'(req_ready), 32'd0);
        out_ready = 1'b1;
      end
      req_valid = N'(4);
      req_data[22 +: 11] = words[w];
      #3;
      if (req_ready[2]) w++;
      step();
    end
    chk("bp_all_accepted", 32'(w), 32'd3);
    req_valid = '0;
    repeat (3) step();
    out_ready = 1'b1;
    for (int c = 0; c < 21; c++) begin
      req_valid = N'(2);
      req_data[11 +: 11] = 11'($urandom);
      step();
      chk("pp_valid", 32'(out_valid), 32'd1);
    end
    req_valid = '0;
    step();
    out_ready = 1'b0;
    req_valid = '1;
    repeat (3) begin
      req_data = 44'({$urandom(), $urandom()});
      step();
    end
    rst = 1'b1;
    req_valid = '0;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_data = 44'({$urandom(), $urandom()});
      #1;
      chk("fair_grant", 32'(req_ready), 32'(1) << (i % N));
      step();
      chk("fair_src", 32'(out_src), 32'(i % N));
    end
    req_valid = '0;
    step();
`ifdef HAM_ENC_SCHED_ERR_INJ_EN
    inj_en = 1'b1;
    inj_pos = 4'd5;
    send(0, 11'h000);
    chk("inj_5", 32'(out_code), 32'h0020);
    inj_pos = 4'd15;
    send(0, 11'h000);
    chk("inj_15", 32'(out_code), 32'h0000);
    inj_en = 1'b0;
    step();
`endif
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom);
      req_data = 44'({$urandom(), $urandom()});
      out_ready = $urandom_range(0, 3) != 0;
`ifdef HAM_ENC_SCHED_ERR_INJ_EN
      inj_en = $urandom_range(0, 3) == 0;
      inj_pos = 4'($urandom);
`endif
      step();
    end
    req_valid = '0;
    out_ready = 1'b1;
    inj_en = 1'b0;
    repeat (5) step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ham_enc_sched.md
Name: ham_enc_sched

Overview:
- Round-robin scheduler that shares one ham_15_11_encoder instance among NUM_REQ requesters.
- Each cycle it grants at most one 11-bit word and encodes it combinationally through the shared encoder.
- The 15-bit codeword, tagged with its source index, goes into a 2-entry output FIFO drained by a valid/ready consumer.
- Sits between the data producers and the channel/decoder test path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SRC_W, 2, width of source tag; must be >= ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  11*NUM_REQ  per-requester data word; requester i occupies bits [11*i+10:11*i].
- req_ready  output  NUM_REQ  one-hot grant; requester i's word is consumed when req_valid[i] & req_ready[i].
- out_valid  output  1  head FIFO entry valid.
- out_code  output  15  head codeword, in ham_15_11_encoder bit order.
- out_src  output  SRC_W  requester index of the head entry.
- out_ready  input  1  consumer accepts the head entry when out_valid is high.
- busy  output  1  high when the FIFO count is nonzero.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, busy=0, FIFO count=0, rr_ptr=0, req_ready=0. out_code and out_src are don't-care while out_valid=0.
- Reset mid-operation: FIFO contents are discarded; any pending handshake in the reset cycle is not accepted.
- Pop: pop = out_valid & out_ready.
- Push: push = (any granted requester) & (count<2). count is the registered value; a same-cycle pop does not enable a push at count=2.
- req_ready is combinational from req_valid, rr_ptr and count. It is all-zero when count==2 or when no requester is valid.
- Arbitration: grant the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ. At most one bit of req_ready is high.
- Pointer update: on push, rr_ptr <= (granted index + 1) mod NUM_REQ. With no push, rr_ptr holds.
- Encoding: the granted req_data slice drives the shared encoder. Its 15-bit result and the granted index are written into the FIFO tail on push.
- FIFO states:
  - EMPTY (count 0): push -> ONE.
  - ONE (count 1): push only -> TWO; pop only -> EMPTY; push & pop -> ONE, with the new entry becoming head.
  - TWO (count 2): push is blocked; pop -> ONE.
- Ordering: out_valid = (count!=0), and out_code/out_src always reflect the head entry, in FIFO order.
- Latency: a word granted in cycle t appears at out_* in cycle t+1 when the FIFO was empty, or after the earlier entries drain.
- Throughput: one word per cycle is sustained while out_ready is held high.
- Invariant: head data stays stable while out_valid=1 and out_ready=0.
- req_valid deasserted before grant: the request is dropped; it is not latched.

Optional Feature:
- Macro: HAM_ENC_SCHED_ERR_INJ_EN.
- When defined:
  - Adds inputs inj_en (1 bit) and inj_pos (4 bits).
  - On a push with inj_en=1 and inj_pos<15, bit inj_pos of the stored codeword is inverted.
  - inj_pos==15 means no flip.
  - Injection state is sampled per push only; entries already in the FIFO are not affected.
- When undefined: the ports are absent and codewords are stored unmodified.

Test Plan:
- Encode values: after reset, req 0 sends 11'h001 with out_ready=1. Expect out_valid in the next cycle with out_code=15'h0007 and out_src=0. Also check 11'h000->15'h0000, 11'h7FF->15'h7FFF and 11'h400->15'h408B.
- Fairness: all 4 req_valid held high with out_ready=1. Expect grants in order 0,1,2,3,0,1, one per cycle, with out_src following the same sequence.
- Backpressure: out_ready=0 with req 2 streaming 11'h0AA, 11'h0BB, 11'h0CC. Expect exactly two accepts, then req_ready=0 with head stable. Raise out_ready: codes appear in order and the third word is accepted only after the first pop.
- Simultaneous push/pop at count=1: expect count to stay 1, out_valid to stay high, and no entry lost or duplicated across 20 cycles of random data (checked against a scoreboard).
- Reset mid-stream: assert rst with count=2. Next cycle out_valid=0 and req_ready=0; after rst, the first grant goes to req 0 when all requesters are valid.
- Error injection (macro defined): inj_en=1, inj_pos=5, data 11'h000 gives out_code=15'h0020. With inj_pos=15, out_code=15'h0000.
